mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between instruction fetch (IF) and the load/store path (LS).
//  Captures one request per arbitration, drives it to memory and waits for the response.
//  Routes the response back to the owning requester.
//  Sits between the fetch/LSU logic driven by the control unit (mem_wren, mem_byte/mem_halfword -> ls_we/ls_be) and the memory macro.
//  One transaction outstanding at a time; LS has priority, with a streak limit that guarantees IF forward progress.
// PARAMETERS
//  ADDR_W         32  address width
//  DATA_W         32  data width (multiple of 8); BE_W = DATA_W/8 derived
//  MAX_LS_STREAK  4   consecutive LS grants allowed while IF waits (>=1)
// PORTS
//  clk_i        in   1       clock, all state on rising edge
//  rst_ni       in   1       asynchronous active-low reset
//  if_req_i     in   1       IF read request; held with if_addr_i until if_gnt_o
//  if_addr_i    in   ADDR_W  IF read address
//  if_gnt_o     out  1       IF request captured (1-cycle pulse)
//  if_rvalid_o  out  1       IF read data valid (1-cycle pulse)
//  if_rdata_o   out  DATA_W  IF read data, = mem_rdata_i
//  ls_req_i     in   1       LS request; held with payload until ls_gnt_o
//  ls_we_i      in   1       1 = store, 0 = load
//  ls_be_i      in   BE_W    byte enables
//  ls_addr_i    in   ADDR_W  LS address
//  ls_wdata_i   in   DATA_W  LS store data
//  ls_gnt_o     out  1       LS request captured (1-cycle pulse)
//  ls_rvalid_o  out  1       LS response: load data valid or store ack (1-cycle pulse)
//  ls_rdata_o   out  DATA_W  LS load data, = mem_rdata_i
//  mem_req_o    out  1       memory request; held until mem_gnt_i
//  mem_we_o     out  1       memory write enable (registered)
//  mem_be_o     out  BE_W    memory byte enables (registered)
//  mem_addr_o   out  ADDR_W  memory address (registered)
//  mem_wdata_o  out  DATA_W  memory write data (registered)
//  mem_gnt_i    in   1       memory accepted the request
//  mem_rvalid_i in   1       memory response valid; one per accepted request, reads and writes
//  mem_rdata_i  in   DATA_W  memory read data
//  busy_o       out  1       state != IDLE
//  err_o        out  1       sticky protocol error
// BEHAVIOUR
//  Reset: state=IDLE; owner=IF; streak=0; err_o=0; all mem_* regs 0.
//  Reset: all gnt/rvalid/req outputs 0. Reset mid-transaction drops it; mem_req_o falls asynchronously.
//  States:
//   IDLE: arbitrate. A capture loads mem_* regs and owner, pulses the winner's gnt_o in this cycle, and moves to REQ.
//   IDLE, winner selection: LS wins if ls_req_i unless (if_req_i && streak==MAX_LS_STREAK), then IF wins.
//   IDLE, IF capture: mem_we=0, mem_be=all-ones, mem_wdata=0.
//   IDLE, no request: stay in IDLE.
//   REQ: mem_req_o=1, payload stable. On mem_gnt_i go to WAIT.
//   REQ: if mem_gnt_i and mem_rvalid_i in the same cycle, route the response and go to IDLE (zero-latency memory).
//   WAIT: mem_req_o=0. On mem_rvalid_i pulse the owner's rvalid_o and go to IDLE.
//  Latency: gnt in capture cycle C; mem_req_o from C+1; minimum turnaround is IDLE-to-IDLE in 2 cycles.
//  Arbitration happens only in IDLE: next capture is the cycle after the response.
//  Streak: increments on LS capture, saturating at MAX_LS_STREAK. Clears to 0 on IF capture.
//  Streak: while IF is idle, streak saturates but never blocks LS.
//  Requester inputs are ignored outside IDLE; gnt_o is 0 outside IDLE.
//  rdata outputs follow mem_rdata_i combinationally; meaningful only with rvalid.
//  Non-owner rvalid is always 0.
//  err_o set (sticky until reset) on mem_rvalid_i in IDLE, or in REQ without mem_gnt_i. Such a response is dropped.
//  err_o set on mem_gnt_i outside REQ. Such a grant is ignored.
// TESTING
//  1. IF-only read 0x100, memory gnt +1 cycle, rvalid +2 cycles, data 0xDEADBEEF:
//     if_gnt_o in cycle 0; mem_req_o cycles 1-2; if_rvalid_o with 0xDEADBEEF; ls_rvalid_o stays 0.
//  2. IF and LS request in the same IDLE cycle, streak=0: LS granted first; IF granted in the next IDLE.
//  3. LS requests back-to-back with IF held high, MAX_LS_STREAK=4: 4 LS grants, then IF; streak returns to 0.
//  4. LS store we=1, be=4'b0011, addr 0x2000, data 0x1234: mem_* regs match exactly; ls_rvalid_o pulses as ack.
//  5. Zero-latency memory, gnt and rvalid in the same REQ cycle:
//     owner rvalid pulses that cycle; IDLE next cycle; err_o=0.
//  6. Two fault cases:
//     rst_ni low during WAIT: outputs reset immediately; a late rvalid after reset sets err_o.
//     mem_rvalid_i in IDLE: err_o=1 and stays set.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the arbiter and the memory macro.
// slave = arbiter view; master = requester/memory side view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              ls_req_i;
    logic              ls_we_i;
    logic [BE_W-1:0]   ls_be_i;
    logic [ADDR_W-1:0] ls_addr_i;
    logic [DATA_W-1:0] ls_wdata_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DATA_W-1:0] ls_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              busy_o;
    logic              err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output busy_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  busy_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// IF/LS arbiter for one single-port memory, one transaction outstanding; gnt in capture cycle, IDLE-to-IDLE >= 2 cycles.
// Requests are held by the requester until gnt; mem_req_o is held until mem_gnt_i; LS priority with a bounded streak.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    mem_port_arbiter_if.slave     bus
);
    localparam int BE_W   = DATA_W / 8;
    localparam int STRK_W = $clog2(MAX_LS_STREAK + 1);
    localparam logic [STRK_W-1:0] STREAK_MAX = STRK_W'(MAX_LS_STREAK);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic              owner_ls_q,  owner_ls_d;
    logic [STRK_W-1:0] streak_q,    streak_d;
    logic              err_q,       err_d;
    logic              mem_we_q,    mem_we_d;
    logic [BE_W-1:0]   mem_be_q,    mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic ls_win;
    logic if_win;
    logic resp_vld;

    always_comb begin
        // IF only overrides LS once LS has used up its streak while IF was waiting
        ls_win      = bus.ls_req_i && !(bus.if_req_i && (streak_q == STREAK_MAX));
        if_win      = bus.if_req_i && !ls_win;
        resp_vld    = 1'b0;
        state_d     = state_q;
        owner_ls_d  = owner_ls_q;
        streak_d    = streak_q;
        err_d       = err_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.mem_rvalid_i || bus.mem_gnt_i) begin
                    err_d = 1'b1;
                end
                if (ls_win) begin
                    state_d     = ST_REQ;
                    owner_ls_d  = 1'b1;
                    streak_d    = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
                    mem_we_d    = bus.ls_we_i;
                    mem_be_d    = bus.ls_be_i;
                    mem_addr_d  = bus.ls_addr_i;
                    mem_wdata_d = bus.ls_wdata_i;
                end else if (if_win) begin
                    state_d     = ST_REQ;
                    owner_ls_d  = 1'b0;
                    streak_d    = '0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = bus.if_addr_i;
                    mem_wdata_d = '0;
                end
            end
            ST_REQ: begin
                if (bus.mem_gnt_i) begin
                    if (bus.mem_rvalid_i) begin
                        resp_vld = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_WAIT;
                    end
                end else if (bus.mem_rvalid_i) begin
                    err_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.mem_gnt_i) begin
                    err_d = 1'b1;
                end
                if (bus.mem_rvalid_i) begin
                    resp_vld = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            owner_ls_q  <= 1'b0;
            streak_q    <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_ls_q  <= owner_ls_d;
            streak_q    <= streak_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // state_q is IDLE during reset, so grants are also masked by rst_ni directly
    assign bus.if_gnt_o    = rst_ni && (state_q == ST_IDLE) && if_win;
    assign bus.ls_gnt_o    = rst_ni && (state_q == ST_IDLE) && ls_win;
    assign bus.if_rvalid_o = resp_vld && !owner_ls_q;
    assign bus.ls_rvalid_o = resp_vld &&  owner_ls_q;
    assign bus.if_rdata_o  = bus.mem_rdata_i;
    assign bus.ls_rdata_o  = bus.mem_rdata_i;

    assign bus.mem_req_o   = (state_q == ST_REQ);
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_be_o    = mem_be_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-computed expectations, inputs driven and outputs sampled around negedge.
module tb_mem_port_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LS_STREAK(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.if_req_i     = 1'b0;
        bus.if_addr_i    = '0;
        bus.ls_req_i     = 1'b0;
        bus.ls_we_i      = 1'b0;
        bus.ls_be_i      = 4'hF;
        bus.ls_addr_i    = '0;
        bus.ls_wdata_i   = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    // Checks the IDLE-cycle grant pair, then advances into REQ.
    task automatic capture(input string tag, input bit exp_ls);
        #1;
        check({tag, "_if_gnt"}, bus.if_gnt_o, !exp_ls);
        check({tag, "_ls_gnt"}, bus.ls_gnt_o, exp_ls);
        step();
    endtask

    // Starting in REQ: memory grants after gwait cycles, responds rwait cycles after grant (0 = same cycle).
    task automatic xact(input string tag, input bit own_ls, input int gwait, input int rwait,
                        input logic [31:0] rdata);
        repeat (gwait) begin
            #1 check({tag, "_req_hold"}, bus.mem_req_o, 1);
            step();
        end
        bus.mem_gnt_i = 1'b1;
        if (rwait == 0) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = rdata;
        end
        #1 check({tag, "_req_at_gnt"}, bus.mem_req_o, 1);
        if (rwait == 0) begin
            check({tag, "_own_rv0"},  own_ls ? bus.ls_rvalid_o : bus.if_rvalid_o, 1);
            check({tag, "_oth_rv0"},  own_ls ? bus.if_rvalid_o : bus.ls_rvalid_o, 0);
            check({tag, "_rdata0"},   own_ls ? bus.ls_rdata_o  : bus.if_rdata_o, rdata);
        end
        step();
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        if (rwait > 0) begin
            repeat (rwait - 1) begin
                #1 check({tag, "_wait_rv"}, bus.if_rvalid_o | bus.ls_rvalid_o, 0);
                step();
            end
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = rdata;
            #1;
            check({tag, "_wait_req"}, bus.mem_req_o, 0);
            check({tag, "_own_rv"},   own_ls ? bus.ls_rvalid_o : bus.if_rvalid_o, 1);
            check({tag, "_oth_rv"},   own_ls ? bus.if_rvalid_o : bus.ls_rvalid_o, 0);
            check({tag, "_rdata"},    own_ls ? bus.ls_rdata_o  : bus.if_rdata_o, rdata);
            step();
            bus.mem_rvalid_i = 1'b0;
        end
        #1;
        check({tag, "_idle"}, bus.busy_o, 0);
        check({tag, "_err"},  bus.err_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        bus.if_req_i = 1'b1;
        @(negedge clk); #1;
        check("rst_if_gnt",  bus.if_gnt_o, 0);
        check("rst_busy",    bus.busy_o, 0);
        check("rst_mem_req", bus.mem_req_o, 0);
        check("rst_err",     bus.err_o, 0);
        check("rst_be",      bus.mem_be_o, 0);
        check("rst_streak",  dut.streak_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.if_req_i = 1'b0;

        // IF-only read
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        capture("t1", 0);
        bus.if_req_i = 1'b0;
        check("t1_addr", bus.mem_addr_o, 32'h100);
        check("t1_we",   bus.mem_we_o, 0);
        check("t1_be",   bus.mem_be_o, 4'hF);
        xact("t1", 0, 1, 1, 32'hDEADBEEF);

        // simultaneous IF/LS, streak 0: LS first
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h300;
        bus.ls_req_i  = 1'b1;
        bus.ls_addr_i = 32'h400;
        capture("t2a", 1);
        bus.ls_req_i = 1'b0;
        check("t2_ls_addr",  bus.mem_addr_o, 32'h400);
        check("t2_if_noreq", bus.if_gnt_o, 0);
        xact("t2a", 1, 0, 1, 32'hAAAA5555);
        capture("t2b", 0);
        bus.if_req_i = 1'b0;
        check("t2_if_addr", bus.mem_addr_o, 32'h300);
        xact("t2b", 0, 0, 2, 32'h0BADF00D);

        // LS streak with IF held, zero-latency memory
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h500;
        bus.ls_req_i  = 1'b1;
        bus.ls_addr_i = 32'h600;
        for (int i = 0; i < 4; i++) begin
            capture("t3_ls", 1);
            xact("t3_ls", 1, 0, 0, 32'(i + 1));
        end
        check("t3_streak_max", dut.streak_q, 4);
        capture("t3_if", 0);
        check("t3_streak_clr", dut.streak_q, 0);
        check("t3_if_addr",    bus.mem_addr_o, 32'h500);
        bus.if_req_i = 1'b0;
        bus.ls_req_i = 1'b0;
        xact("t3_if", 0, 0, 0, 32'hCAFE0001);

        // LS store
        bus.ls_req_i   = 1'b1;
        bus.ls_we_i    = 1'b1;
        bus.ls_be_i    = 4'b0011;
        bus.ls_addr_i  = 32'h2000;
        bus.ls_wdata_i = 32'h1234;
        capture("t4", 1);
        bus.ls_req_i = 1'b0;
        bus.ls_we_i  = 1'b0;
        check("t4_we",    bus.mem_we_o, 1);
        check("t4_be",    bus.mem_be_o, 4'b0011);
        check("t4_addr",  bus.mem_addr_o, 32'h2000);
        check("t4_wdata", bus.mem_wdata_o, 32'h1234);
        xact("t4", 1, 2, 1, 32'h0);

        // reset while in REQ: mem_req_o drops without a clock edge
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h700;
        capture("t6r", 0);
        bus.if_req_i = 1'b0;
        #1 check("t6r_req_pre", bus.mem_req_o, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6r_req_async", bus.mem_req_o, 0);
        check("t6r_addr_rst",  bus.mem_addr_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset while in WAIT, then a late response
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h800;
        capture("t6w", 0);
        bus.if_req_i  = 1'b0;
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0;
        #1 check("t6w_busy_pre", bus.busy_o, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6w_busy_rst", bus.busy_o, 0);
        check("t6w_be_rst",   bus.mem_be_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("t6w_err_clr", bus.err_o, 0);
        bus.mem_rvalid_i = 1'b1;
        #1 check("t6w_late_rv", bus.if_rvalid_o | bus.ls_rvalid_o, 0);
        step();
        bus.mem_rvalid_i = 1'b0;
        #1 check("t6w_late_err", bus.err_o, 1);

        // stray response in IDLE: sticky error
        rst_n = 1'b0;
        #1 check("t6i_err_rst", bus.err_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        step();
        bus.mem_rvalid_i = 1'b0;
        #1 check("t6i_err_set", bus.err_o, 1);
        step(); step();
        #1 check("t6i_err_sticky", bus.err_o, 1);

        // stray grant in IDLE
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0;
        #1;
        check("t6g_err_set", bus.err_o, 1);
        check("t6g_busy",    bus.busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
